// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF input sync, oversampled start/data/stop sampling, one-deep holding register.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined (adds PARITY_ODD and parity_err).
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  rxd,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  frame_err,
  output logic                  overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                  state, state_n;
  logic                    rxd_meta, rxd_s;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic [OS_W-1:0]         os_cnt, os_n;
  logic [BIT_W-1:0]        bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0]   shift, shift_n;
  logic                    char_done, ferr_c;
`ifdef UART_RX_PARITY_EN
  logic                    par_bit, par_n, perr_c;
`endif

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst)                   div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state   <= S_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    os_n      = os_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift;
    char_done = 1'b0;
    ferr_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n     = par_bit;
    perr_c    = 1'b0;
`endif
    if (tick) begin
      case (state)
        S_IDLE: begin
          os_n = '0;
          if (!rxd_s) state_n = S_START;
        end
        S_START: begin
          // Mid start bit: a line that has already gone high was only a glitch.
          if (os_cnt == OS_MID) begin
            os_n    = '0;
            bit_n   = '0;
            state_n = rxd_s ? S_IDLE : S_DATA;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (os_cnt == OS_LAST) begin
            os_n    = '0;
            shift_n = {rxd_s, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_n = '0;
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (os_cnt == OS_LAST) begin
            os_n    = '0;
            par_n   = rxd_s;
            state_n = S_STOP;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Leave at mid stop bit so the next start edge is caught without delay.
          if (os_cnt == OS_LAST) begin
            os_n    = '0;
            state_n = S_IDLE;
            if (!rxd_s) ferr_c = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if ((^shift ^ par_bit) != PARITY_ODD) perr_c = 1'b1;
`endif
            else char_done = 1'b1;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          os_n    = '0;
        end
      endcase
    end
  end

  // Handshake: rx_valid/rx_data hold until a cycle with rx_valid & rx_ready; a character
  // completing while full is dropped (overrun), one completing during a handshake is loaded.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= ferr_c;
      overrun    <= char_done && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_c;
`endif
      if (char_done && !(rx_valid && !rx_ready)) begin
        rx_valid <= 1'b1;
        rx_data  <= shift;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at default parameters (64 pclk per bit); frames are driven bit by bit
// and a negedge monitor collects delivered characters and error pulses for the tests to compare.
module tb_uart_rx_core;

  localparam int BIT_CYC = 64;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_TICKS = 8 + 16 * (8 + PB) + 16;

  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int rise_cyc = -1;
  int vcyc_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int perr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_core dut (
    .pclk      (pclk),
    .prst      (prst),
    .rxd       (rxd),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // clock / reset-relative edge counter
  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (prst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // monitor
  always @(negedge pclk) begin
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_valid;
    if (rx_valid) vcyc_cnt <= vcyc_cnt + 1;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    step(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      step(BIT_CYC);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^d;
    step(BIT_CYC);
`endif
    rxd = stop_bit;
    step(BIT_CYC);
    rxd = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    step(3);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", rx_valid); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", rx_data); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    prst = 1'b0;
    step(10);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b want 0", rx_valid); end
  endtask

  task automatic test_basic();
    int base, v0, f0, o0, t0, exp_rise;
    rx_ready = 1'b1;
    step(10);
    base = got_q.size(); v0 = vcyc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    // first tick seeing the synchronised low, then the whole frame in ticks; ticks land on edges 4,8,12...
    t0 = cyc + 3;
    while (t0 % 4 != 0) t0++;
    exp_rise = t0 + 4 * FRAME_TICKS;
    send_frame(8'hA5, 1'b1);
    step(40);
    checks++;
    if (rise_cyc !== exp_rise) begin errors++; $display("FAIL basic_latency got edge %0d want %0d", rise_cyc, exp_rise); end
    checks++;
    if (vcyc_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_width got %0d want 1", vcyc_cnt - v0); end
    checks++;
    if (got_q.size() - base !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", got_q.size() - base); end
    else if (got_q[base] !== 8'hA5) begin errors++; $display("FAIL basic_data got %02h want a5", got_q[base]); end
    checks++;
    if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
      errors++; $display("FAIL basic_errors got fe %0d ov %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_glitch();
    int v0, f0, o0;
    v0 = vcyc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rxd = 1'b0;
    step(20);
    rxd = 1'b1;
    step(4 * BIT_CYC);
    checks++;
    if (vcyc_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", vcyc_cnt - v0); end
    checks++;
    if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
      errors++; $display("FAIL glitch_errors got fe %0d ov %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_frame_err();
    int base, v0, f0;
    base = got_q.size(); v0 = vcyc_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    step(2 * BIT_CYC);
    checks++;
    if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL frame_err_pulses got %0d want 1", ferr_cnt - f0); end
    checks++;
    if (vcyc_cnt - v0 !== 0) begin errors++; $display("FAIL frame_err_valid got %0d want 0", vcyc_cnt - v0); end
    send_frame(8'h5A, 1'b1);
    step(40);
    checks++;
    if (got_q.size() - base !== 1) begin errors++; $display("FAIL frame_err_next_count got %0d want 1", got_q.size() - base); end
    else if (got_q[base] !== 8'h5A) begin errors++; $display("FAIL frame_err_next_data got %02h want 5a", got_q[base]); end
    checks++;
    if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL frame_err_after got %0d want 1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun();
    int base, o0;
    base = got_q.size(); o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(40);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_hold_valid got %0b want 1", rx_valid); end
    checks++;
    if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_hold_data got %02h want 11", rx_data); end
    checks++;
    if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", ovr_cnt - o0); end
    rx_ready = 1'b1;
    step(1);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_clear got %0b want 0", rx_valid); end
    step(2);
    checks++;
    if (got_q.size() - base !== 1) begin errors++; $display("FAIL overrun_handshakes got %0d want 1", got_q.size() - base); end
    else if (got_q[base] !== 8'h11) begin errors++; $display("FAIL overrun_data got %02h want 11", got_q[base]); end
  endtask

  task automatic test_back_to_back();
    int base, f0, o0;
    logic [7:0] exp_q[$];
    base = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q = '{8'h00, 8'hFF, 8'h81};
    rx_ready = 1'b1;
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1);
    step(40);
    checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_data[%0d] got %02h want %02h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0 || both_cnt !== 0) begin
      errors++; $display("FAIL b2b_errors got fe %0d ov %0d both %0d want 0 0 0", ferr_cnt - f0, ovr_cnt - o0, both_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int base, f0;
    logic [7:0] d;
    base = got_q.size(); f0 = ferr_cnt;
    d = 8'h77;
    rxd = 1'b0;
    step(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      step(BIT_CYC);
    end
    rxd = d[4];
    step(30);
    prst = 1'b1;
    step(4);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b want 0", rx_valid); end
    rxd = 1'b1;
    prst = 1'b0;
    step(2 * BIT_CYC);
    send_frame(8'h99, 1'b1);
    step(40);
    checks++;
    if (got_q.size() - base !== 1) begin errors++; $display("FAIL midreset_count got %0d want 1", got_q.size() - base); end
    else if (got_q[base] !== 8'h99) begin errors++; $display("FAIL midreset_data got %02h want 99", got_q[base]); end
    checks++;
    if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midreset_frame_err got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_random();
    int base, f0, exp_fe;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic good;
    base = got_q.size(); f0 = ferr_cnt; exp_fe = 0;
    rx_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      if (good) exp_q.push_back(d);
      else exp_fe++;
      send_frame(d, good);
      // a broken stop bit leaves the line low; give it a full idle bit before the next start
      if (good) step($urandom_range(1, 40));
      else      step(BIT_CYC + $urandom_range(0, 20));
    end
    step(40);
    checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_data[%0d] got %02h want %02h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ferr_cnt - f0 !== exp_fe) begin errors++; $display("FAIL rand_frame_err got %0d want %0d", ferr_cnt - f0, exp_fe); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int base, p0, f0;
    logic [7:0] d;
    base = got_q.size(); p0 = perr_cnt; f0 = ferr_cnt;
    d = 8'h07;
    rxd = 1'b0;
    step(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      step(BIT_CYC);
    end
    rxd = 1'b0;
    step(BIT_CYC);
    rxd = 1'b1;
    step(BIT_CYC);
    step(40);
    checks++;
    if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL parity_pulses got %0d want 1", perr_cnt - p0); end
    checks++;
    if (got_q.size() - base !== 0 || ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL parity_discard got rx %0d fe %0d want 0 0", got_q.size() - base, ferr_cnt - f0);
    end
  endtask
`endif

  initial begin
    @(posedge pclk);
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver that sits directly upstream of the APB slave's RX interface.
- Deserialises the asynchronous serial line `rxd` (8N1 by default) using a pclk-derived oversampling tick.
- Presents each received character on a valid/ready handshake (`rx_valid`/`rx_ready`/`rx_data`) that connects straight into the APB slave.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- DATA_WIDTH, 8, data bits per character; equals the APB slave DATA_WIDTH.
- CLK_DIV, 4, pclk cycles per oversample tick; legal range ≥ 1.
- OVERSAMPLE, 16, ticks per bit period; must be even and ≥ 4.

Ports:
- pclk  input  1  system clock.
- prst  input  1  asynchronous reset, active-high.
- rxd  input  1  serial line, idle high, asynchronous to pclk.
- rx_valid  output  1  received character available.
- rx_ready  input  1  consumer accepts character.
- rx_data  output  DATA_WIDTH  received character, LSB = first data bit.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: character dropped because the holding register was full.

Behaviour:
- Interface decision: one clock (pclk); reset prst is asynchronous and active-high.
- Reset values:
  - rx_valid = 0, rx_data = 0, frame_err = 0, overrun = 0.
  - 2-FF synchroniser flops = 1; FSM = IDLE; all counters = 0.
- Input sync: rxd passes through a 2-FF synchroniser; all decisions use the synchronised value rxd_s.
- Tick generator:
  - Free-running counter 0..CLK_DIV-1.
  - `tick` = 1 for one pclk cycle when the counter equals CLK_DIV-1.
  - CLK_DIV = 1 gives a tick every cycle.
- Counters:
  - os_cnt counts ticks within a bit, range 0..OVERSAMPLE-1.
  - bit_cnt counts data bits, range 0..DATA_WIDTH-1.
  - Both advance only on tick.
- FSM states, transitions evaluated only on tick:
  - IDLE: os_cnt held at 0. If rxd_s = 0, go to START with os_cnt = 0.
  - START: os_cnt increments. At os_cnt = OVERSAMPLE/2-1 (mid start bit):
    - rxd_s = 0: go to DATA, os_cnt = 0, bit_cnt = 0.
    - rxd_s = 1: false start (glitch); return to IDLE with no outputs.
  - DATA: at os_cnt = OVERSAMPLE-1, shift rxd_s into the shift register MSB-side (LSB-first reception) and reset os_cnt to 0. After bit_cnt = DATA_WIDTH-1, go to STOP (or PARITY when the optional feature is enabled); otherwise increment bit_cnt.
  - STOP: at os_cnt = OVERSAMPLE-1, sample rxd_s and return to IDLE in that same tick, so back-to-back frames resynchronise on the next start edge.
    - rxd_s = 1: character complete.
    - rxd_s = 0: frame_err pulses next cycle; character discarded; rx_valid and rx_data unchanged.
- Output holding register, latency:
  - On character completion, rx_valid rises on the pclk edge after the stop-sample tick.
  - rx_data updates on that same edge.
- Handshake:
  - rx_valid stays high and rx_data stays stable until a cycle with rx_valid = 1 and rx_ready = 1.
  - rx_valid clears on the edge after that handshake.
  - rx_ready is ignored while rx_valid = 0.
- Completion while full (rx_valid = 1, rx_ready = 0 in that cycle): new character dropped, rx_data keeps the old value, overrun pulses for 1 cycle.
- Completion in the same cycle as a handshake: new character loaded, rx_valid stays 1, no overrun.
- Reset mid-frame: frame aborted immediately; all state returns to reset values; no partial character is emitted after release.
- frame_err and overrun never pulse in the same cycle; they are independent of rx_ready.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds parameter PARITY_ODD (default 0 = even parity) and output parity_err (1-bit pulse).
  - Adds state PARITY between DATA and STOP, sampled at os_cnt = OVERSAMPLE-1.
  - On mismatch, parity_err pulses 1 cycle at character completion and the character is discarded, as for frame_err.
  - If the stop bit is also bad, only frame_err pulses.
- When undefined: no PARITY state, no parity_err port; frame is 8N1.

Test Plan:
- Defaults (CLK_DIV=4, OVERSAMPLE=16, i.e. 64 pclk/bit), rx_ready=1, send 0xA5 → rx_valid high exactly 1 cycle, rx_data=0xA5, asserted 1 pclk after the stop-bit mid-sample tick; frame_err=0, overrun=0.
- rxd low for 20 pclk cycles (under half a bit), then high → FSM returns to IDLE; rx_valid, frame_err and overrun stay 0.
- Send 0x3C with the stop bit driven low → frame_err pulses 1 cycle, rx_valid stays 0; a following valid 0x5A → rx_data=0x5A.
- rx_ready=0, send 0x11 then 0x22 → rx_data=0x11 held, overrun pulses once on 0x22 completion; then rx_ready=1 → one handshake, rx_valid clears.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap, rx_ready=1 → three valid pulses with data in order, no errors.
- Assert prst during bit 4 of 0x77, release, then send 0x99 → only 0x99 is delivered. With UART_RX_PARITY_EN, even parity, send 0x07 with parity bit 0 → parity_err pulses and no rx_valid.
